// File: rtl/mips_cpu_seq_ctrl.sv
// Multi-cycle sequencing controller for the MIPS core: fetch/exec/mem/wb over one
// stallable memory port, iterative muldiv wait, optional branch delay slot, halt at PC 0.
module mips_cpu_seq_ctrl #(
    parameter int unsigned MULDIV_LATENCY = 32,
    parameter int unsigned DELAY_SLOT     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] instr_op,
    input  logic [5:0] instr_funct,
    input  logic [4:0] instr_rt,
    input  logic       branch_cond,
    input  logic       pc_zero,
    input  logic       waitrequest,
    output logic       active,
    output logic       instr_read,
    output logic       ir_en,
    output logic       data_read,
    output logic       data_write,
    output logic       regwrite,
    output logic       link_sel,
    output logic       memtoreg,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       target_en,
    output logic       hilo_write,
    output logic       muldiv_start,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC   = 3'd1,
        S_MEM    = 3'd2,
        S_WB     = 3'd3,
        S_MULDIV = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               delay_pending, delay_pending_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic is_alu, is_mthilo, is_muldiv, is_branch, is_jump, is_link, is_load, is_store;
    logic taken, redirect;

    // Instruction class decode from the IR fields
    always_comb begin
        is_alu    = 1'b0;
        is_mthilo = 1'b0;
        is_muldiv = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_link   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (instr_op)
            6'h00: begin
                case (instr_funct)
                    6'h08:                      is_jump = 1'b1;
                    6'h09:                      begin is_jump = 1'b1; is_link = 1'b1; end
                    6'h11, 6'h13:               is_mthilo = 1'b1;
                    6'h18, 6'h19, 6'h1A, 6'h1B: is_muldiv = 1'b1;
                    default:                    is_alu = 1'b1;
                endcase
            end
            6'h01: begin
                case (instr_rt)
                    5'h00, 5'h01: is_branch = 1'b1;
                    5'h10, 5'h11: begin is_branch = 1'b1; is_link = 1'b1; end
                    default: ;
                endcase
            end
            6'h02:                      is_jump = 1'b1;
            6'h03:                      begin is_jump = 1'b1; is_link = 1'b1; end
            6'h04, 6'h05, 6'h06, 6'h07: is_branch = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: is_alu = 1'b1;
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26:        is_load = 1'b1;
            6'h28, 6'h29, 6'h2B:        is_store = 1'b1;
            default: ;
        endcase
    end

    // Next state and combinational strobes
    always_comb begin
        state_d         = state_q;
        delay_pending_d = delay_pending;
        cnt_d           = cnt;
        active          = (state_q != S_HALTED);
        instr_read      = 1'b0;
        ir_en           = 1'b0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        regwrite        = 1'b0;
        link_sel        = 1'b0;
        memtoreg        = 1'b0;
        pc_en           = 1'b0;
        pc_sel          = 1'b0;
        target_en       = 1'b0;
        hilo_write      = 1'b0;
        muldiv_start    = 1'b0;
        state           = state_q;
        taken           = is_jump | (is_branch & branch_cond);
        redirect        = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (pc_zero) begin
                    state_d = S_HALTED;
                end else begin
                    instr_read = 1'b1;
                    if (!waitrequest) begin
                        ir_en   = 1'b1;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_muldiv) begin
                    muldiv_start = 1'b1;
                    cnt_d        = CNT_W'(MULDIV_LATENCY - 1);
                    state_d      = S_MULDIV;
                end else begin
                    regwrite   = is_alu | is_link;
                    link_sel   = is_link;
                    hilo_write = is_mthilo;
                    pc_en      = 1'b1;
                    state_d    = S_FETCH;
                    // A branch sitting in a delay slot links but never redirects
                    if (taken && !delay_pending) begin
                        target_en = 1'b1;
                        if (DELAY_SLOT != 0) delay_pending_d = 1'b1;
                        else                 redirect        = 1'b1;
                    end
                end
            end
            S_MEM: begin
                data_read  = is_load;
                data_write = is_store;
                if (!waitrequest) begin
                    if (is_store) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                pc_en    = 1'b1;
                state_d  = S_FETCH;
            end
            S_MULDIV: begin
                if (cnt == '0) begin
                    hilo_write = 1'b1;
                    pc_en      = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_HALTED: ;
            default: state_d = S_FETCH;
        endcase

        // Retiring the delay-slot instruction consumes the pending redirect
        pc_sel = pc_en & (delay_pending | redirect);
        if (pc_en && delay_pending) delay_pending_d = 1'b0;

        if (reset) begin
            active       = 1'b0;
            instr_read   = 1'b0;
            ir_en        = 1'b0;
            data_read    = 1'b0;
            data_write   = 1'b0;
            regwrite     = 1'b0;
            link_sel     = 1'b0;
            memtoreg     = 1'b0;
            pc_en        = 1'b0;
            pc_sel       = 1'b0;
            target_en    = 1'b0;
            hilo_write   = 1'b0;
            muldiv_start = 1'b0;
            state        = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            delay_pending <= 1'b0;
            cnt           <= '0;
        end else begin
            state_q       <= state_d;
            delay_pending <= delay_pending_d;
            cnt           <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_seq_ctrl.sv
// Bench for mips_cpu_seq_ctrl: two instances (delay slot on/off) checked per cycle
// against a per-instruction trace model built from the instruction-class timing rules.
module tb_mips_cpu_seq_ctrl;

    localparam int LAT = 4;
    localparam int DS_A = 1;
    localparam int DS_B = 0;

    localparam int C_ALU = 0, C_HILOW = 1, C_MULDIV = 2, C_BR = 3, C_BRL = 4,
                   C_J = 5, C_JL = 6, C_LOAD = 7, C_STORE = 8, C_NOP = 9;

    typedef struct packed {
        logic [2:0] st;
        logic active, instr_read, ir_en, data_read, data_write, regwrite, link_sel;
        logic memtoreg, pc_en, pc_sel, target_en, hilo_write, muldiv_start;
    } obs_t;

    logic clk, reset;
    logic [5:0] instr_op, instr_funct;
    logic [4:0] instr_rt;
    logic branch_cond, pc_zero, waitrequest;

    logic act_a, ir_a, ire_a, dr_a, dw_a, rw_a, ls_a, m2r_a, pe_a, ps_a, te_a, hw_a, ms_a;
    logic act_b, ir_b, ire_b, dr_b, dw_b, rw_b, ls_b, m2r_b, pe_b, ps_b, te_b, hw_b, ms_b;
    logic [2:0] st_a, st_b;
    obs_t obs_a, obs_b;

    int checks = 0;
    int errors = 0;
    logic dp_a = 1'b0;
    logic dp_b = 1'b0;

    mips_cpu_seq_ctrl #(.MULDIV_LATENCY(LAT), .DELAY_SLOT(DS_A)) dut_a (
        .clk(clk), .reset(reset), .instr_op(instr_op), .instr_funct(instr_funct),
        .instr_rt(instr_rt), .branch_cond(branch_cond), .pc_zero(pc_zero),
        .waitrequest(waitrequest), .active(act_a), .instr_read(ir_a), .ir_en(ire_a),
        .data_read(dr_a), .data_write(dw_a), .regwrite(rw_a), .link_sel(ls_a),
        .memtoreg(m2r_a), .pc_en(pe_a), .pc_sel(ps_a), .target_en(te_a),
        .hilo_write(hw_a), .muldiv_start(ms_a), .state(st_a));

    mips_cpu_seq_ctrl #(.MULDIV_LATENCY(LAT), .DELAY_SLOT(DS_B)) dut_b (
        .clk(clk), .reset(reset), .instr_op(instr_op), .instr_funct(instr_funct),
        .instr_rt(instr_rt), .branch_cond(branch_cond), .pc_zero(pc_zero),
        .waitrequest(waitrequest), .active(act_b), .instr_read(ir_b), .ir_en(ire_b),
        .data_read(dr_b), .data_write(dw_b), .regwrite(rw_b), .link_sel(ls_b),
        .memtoreg(m2r_b), .pc_en(pe_b), .pc_sel(ps_b), .target_en(te_b),
        .hilo_write(hw_b), .muldiv_start(ms_b), .state(st_b));

    assign obs_a = {st_a, act_a, ir_a, ire_a, dr_a, dw_a, rw_a, ls_a, m2r_a, pe_a, ps_a, te_a, hw_a, ms_a};
    assign obs_b = {st_b, act_b, ir_b, ire_b, dr_b, dw_b, rw_b, ls_b, m2r_b, pe_b, ps_b, te_b, hw_b, ms_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        e.active = 1'b1;
        return e;
    endfunction

    // Instruction class from the opcode table
    function automatic int cls(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
        if (op == 6'h00) begin
            if (fn == 6'h08) return C_J;
            if (fn == 6'h09) return C_JL;
            if (fn == 6'h11 || fn == 6'h13) return C_HILOW;
            if (fn >= 6'h18 && fn <= 6'h1B) return C_MULDIV;
            return C_ALU;
        end
        if (op == 6'h01) begin
            if (rt == 5'h00 || rt == 5'h01) return C_BR;
            if (rt == 5'h10 || rt == 5'h11) return C_BRL;
            return C_NOP;
        end
        if (op == 6'h02) return C_J;
        if (op == 6'h03) return C_JL;
        if (op >= 6'h04 && op <= 6'h07) return C_BR;
        if (op >= 6'h08 && op <= 6'h0F) return C_ALU;
        if (op >= 6'h20 && op <= 6'h26) return C_LOAD;
        if (op == 6'h28 || op == 6'h29 || op == 6'h2B) return C_STORE;
        return C_NOP;
    endfunction

    // One clock: drive waitrequest, compare both instances mid-cycle, advance past the edge
    task automatic cyc(input logic wr, input obs_t ea, input obs_t eb, input string tag);
        waitrequest = wr;
        @(negedge clk);
        chk({tag, "_a"}, obs_a, ea);
        chk({tag, "_b"}, obs_b, eb);
        @(posedge clk);
        #1;
    endtask

    // Retiring cycle: pc_en, and the redirect bookkeeping for each delay-slot setting
    task automatic retire(input obs_t e, input logic tk, input logic wr, input string tag);
        obs_t ea, eb;
        ea = e; eb = e;
        ea.pc_en = 1'b1; eb.pc_en = 1'b1;
        ea.pc_sel = dp_a | (tk & (DS_A == 0));
        eb.pc_sel = dp_b | (tk & (DS_B == 0));
        ea.target_en = tk & ~dp_a;
        eb.target_en = tk & ~dp_b;
        cyc(wr, ea, eb, tag);
        dp_a = (DS_A != 0) && tk && !dp_a;
        dp_b = (DS_B != 0) && tk && !dp_b;
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                            input logic bc, input int fst, input int mst, output int ncyc);
        obs_t e;
        int c;
        logic tk;
        c = cls(op, fn, rt);
        tk = (c == C_J || c == C_JL) || ((c == C_BR || c == C_BRL) && bc);
        instr_op = op; instr_funct = fn; instr_rt = rt; branch_cond = bc;
        ncyc = 0;
        for (int i = 0; i < fst; i++) begin
            e = base(3'd0); e.instr_read = 1'b1;
            cyc(1'b1, e, e, "fetch_wait"); ncyc++;
        end
        e = base(3'd0); e.instr_read = 1'b1; e.ir_en = 1'b1;
        cyc(1'b0, e, e, "fetch"); ncyc++;
        e = base(3'd1);
        if (c == C_LOAD || c == C_STORE) begin
            cyc(1'($urandom_range(0, 1)), e, e, "exec_mem"); ncyc++;
            e = base(3'd2);
            e.data_read = (c == C_LOAD);
            e.data_write = (c == C_STORE);
            for (int i = 0; i < mst; i++) begin
                cyc(1'b1, e, e, "mem_wait"); ncyc++;
            end
            if (c == C_STORE) begin
                retire(e, 1'b0, 1'b0, "mem_store"); ncyc++;
            end else begin
                cyc(1'b0, e, e, "mem_load"); ncyc++;
                e = base(3'd3); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                retire(e, 1'b0, 1'($urandom_range(0, 1)), "wb"); ncyc++;
            end
        end else if (c == C_MULDIV) begin
            e.muldiv_start = 1'b1;
            cyc(1'($urandom_range(0, 1)), e, e, "exec_muldiv"); ncyc++;
            e = base(3'd4);
            for (int i = 0; i < LAT - 1; i++) begin
                cyc(1'($urandom_range(0, 1)), e, e, "muldiv_wait"); ncyc++;
            end
            e.hilo_write = 1'b1;
            retire(e, 1'b0, 1'($urandom_range(0, 1)), "muldiv_done"); ncyc++;
        end else begin
            e.regwrite = (c == C_ALU || c == C_BRL || c == C_JL);
            e.link_sel = (c == C_BRL || c == C_JL);
            e.hilo_write = (c == C_HILOW);
            retire(e, tk, 1'($urandom_range(0, 1)), "exec"); ncyc++;
        end
    endtask

    task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn, output logic [4:0] rt);
        int k;
        logic [1:0] r;
        op = 6'($urandom); fn = 6'($urandom); rt = 5'($urandom);
        k = $urandom_range(0, 13);
        case (k)
            0, 1: begin op = 6'h00; fn = 6'($urandom_range(32, 43)); end
            2: begin op = 6'h00; fn = 6'($urandom_range(16, 19)); end
            3: begin op = 6'h00; fn = 6'($urandom_range(24, 27)); end
            4: begin op = 6'h00; fn = 6'($urandom_range(8, 9)); end
            5: begin
                op = 6'h01;
                r = 2'($urandom_range(0, 3));
                rt = {r[1], 3'b000, r[0]};
                if ($urandom_range(0, 4) == 0) rt = 5'h05;
            end
            6, 7: op = 6'($urandom_range(2, 7));
            8, 9: op = 6'($urandom_range(8, 15));
            10, 11: op = 6'($urandom_range(32, 38));
            12: begin
                r = 2'($urandom_range(0, 2));
                op = (r == 2'd2) ? 6'h2B : (6'h28 + 6'(r));
            end
            default: op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h27;
        endcase
    endtask

    initial begin
        int n;
        obs_t e;
        logic [5:0] op, fn;
        logic [4:0] rt;

        reset = 1'b1; pc_zero = 1'b0; waitrequest = 1'b0; branch_cond = 1'b0;
        instr_op = 6'h00; instr_funct = 6'h21; instr_rt = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        chk("reset_a", obs_a, e);
        chk("reset_b", obs_b, e);
        reset = 1'b0;

        do_instr(6'h00, 6'h21, 5'h00, 1'b0, 0, 0, n);
        chk_int("addu_cycles", n, 2);

        do_instr(6'h23, 6'h15, 5'h07, 1'b0, 0, 3, n);
        chk_int("lw_stall_cycles", n, 7);

        do_instr(6'h2B, 6'h00, 5'h00, 1'b0, 0, 0, n);
        chk_int("sw_cycles", n, 3);

        do_instr(6'h04, 6'h00, 5'h00, 1'b1, 0, 0, n);
        chk_int("beq_cycles", n, 2);
        do_instr(6'h00, 6'h21, 5'h00, 1'b0, 0, 0, n);
        do_instr(6'h00, 6'h21, 5'h00, 1'b0, 1, 0, n);
        chk_int("addu_fetch_wait_cycles", n, 3);

        do_instr(6'h00, 6'h18, 5'h00, 1'b0, 0, 0, n);
        chk_int("mult_cycles", n, 2 + LAT);

        for (int i = 0; i < 250; i++) begin
            rand_instr(op, fn, rt);
            do_instr(op, fn, rt, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                     $urandom_range(0, 3), n);
        end

        // Asynchronous reset in a stalled MEM with a redirect pending
        do_instr(6'h00, 6'h21, 5'h00, 1'b0, 0, 0, n);
        do_instr(6'h04, 6'h00, 5'h00, 1'b1, 0, 0, n);
        instr_op = 6'h23;
        e = base(3'd0); e.instr_read = 1'b1; e.ir_en = 1'b1;
        cyc(1'b0, e, e, "rst_fetch");
        e = base(3'd1);
        cyc(1'b0, e, e, "rst_exec");
        waitrequest = 1'b1;
        @(negedge clk);
        e = base(3'd2); e.data_read = 1'b1;
        chk("rst_mem_a", obs_a, e);
        chk("rst_mem_b", obs_b, e);
        #2 reset = 1'b1;
        #1;
        e = '0;
        chk("rst_async_a", obs_a, e);
        chk("rst_async_b", obs_b, e);
        @(posedge clk);
        #1;
        chk("rst_hold_a", obs_a, e);
        chk("rst_hold_b", obs_b, e);
        reset = 1'b0; waitrequest = 1'b0;
        dp_a = 1'b0; dp_b = 1'b0;
        do_instr(6'h00, 6'h21, 5'h00, 1'b0, 0, 0, n);

        // Halt: JR, its delay-slot ADDU, then PC reaches 0
        do_instr(6'h00, 6'h08, 5'h00, 1'b0, 0, 0, n);
        do_instr(6'h00, 6'h21, 5'h00, 1'b0, 0, 0, n);
        pc_zero = 1'b1;
        e = base(3'd0);
        cyc(1'($urandom_range(0, 1)), e, e, "halt_fetch");
        e = '0; e.st = 3'd5;
        for (int i = 0; i < 11; i++) begin
            pc_zero = 1'($urandom_range(0, 1));
            instr_op = 6'($urandom);
            cyc(1'($urandom_range(0, 1)), e, e, "halted");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
